// File: rtl/byte_word_packer.sv
// -----------------------------------------------------------------------------
// byte_word_packer
//
// Downstream stage of the APF byte data loader. Bytes arriving on the upstream
// write strobe are assembled into 16-bit little-endian words with per-byte
// enables. Completed, evicted or timed-out words are queued in a small FIFO
// that drains to a 16-bit memory controller over a req/ack handshake.
//
// Ports
//   clk_memory  in   1               sole clock
//   reset       in   1               asynchronous, active-high
//   write_en    in   1               upstream byte strobe; only its rising edge counts
//   write_addr  in   ADDRESS_SIZE+1  upstream byte address
//   write_data  in   8               upstream byte
//   mem_req     out  1               FIFO head valid
//   mem_ack     in   1               controller accepts head when mem_req & mem_ack
//   mem_addr    out  ADDRESS_SIZE    word address of head entry
//   mem_wdata   out  16              head data; [7:0] even byte, [15:8] odd byte
//   mem_be      out  2               head byte enables; bit0 = [7:0], bit1 = [15:8]
//   busy        out  1               assembly register valid or FIFO non-empty
//   overflow    out  1               sticky: a word was dropped on a full FIFO
// -----------------------------------------------------------------------------
module byte_word_packer #(
  parameter int ADDRESS_SIZE    = 14,
  parameter int FIFO_DEPTH_LOG2 = 2,
  parameter int FLUSH_TIMEOUT   = 15
) (
  input  logic                    clk_memory,
  input  logic                    reset,
  input  logic                    write_en,
  input  logic [ADDRESS_SIZE:0]   write_addr,
  input  logic [7:0]              write_data,
  output logic                    mem_req,
  input  logic                    mem_ack,
  output logic [ADDRESS_SIZE-1:0] mem_addr,
  output logic [15:0]             mem_wdata,
  output logic [1:0]              mem_be,
  output logic                    busy,
  output logic                    overflow
);

  localparam int DEPTH   = 1 << FIFO_DEPTH_LOG2;
  localparam int CNT_W   = $clog2(FLUSH_TIMEOUT + 1);
  localparam int ENTRY_W = ADDRESS_SIZE + 16 + 2;

  localparam logic [CNT_W-1:0]         TIMEOUT_LAST = CNT_W'(FLUSH_TIMEOUT - 1);
  localparam logic [FIFO_DEPTH_LOG2:0] COUNT_FULL   = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

  // ---------------------------------------------------------------------------
  // Upstream edge detection and lane decode
  // ---------------------------------------------------------------------------
  logic                    prev_en;
  logic                    byte_edge;
  logic [ADDRESS_SIZE-1:0] in_waddr;
  logic [1:0]              in_be;
  logic [15:0]             in_data;

  assign byte_edge = write_en & ~prev_en;
  assign in_waddr  = write_addr[ADDRESS_SIZE:1];
  assign in_be     = write_addr[0] ? 2'b10 : 2'b01;
  // The unused lane is zero so a single-byte word reads cleanly downstream.
  assign in_data   = write_addr[0] ? {write_data, 8'h00} : {8'h00, write_data};

  // ---------------------------------------------------------------------------
  // Assembly register
  // ---------------------------------------------------------------------------
  logic                    asm_valid;
  logic [ADDRESS_SIZE-1:0] asm_addr;
  logic [15:0]             asm_data;
  logic [1:0]              asm_be;
  logic [CNT_W-1:0]        to_cnt;

  logic evict;
  logic full_word;
  logic timeout_hit;
  logic flush;
  logic push;

  // A new byte that cannot merge (other word, or lane already filled) evicts
  // the held word; the new byte then starts a fresh assembly.
  assign evict       = byte_edge & asm_valid &
                       ((in_waddr != asm_addr) | (|(asm_be & in_be)));
  // A completed word sits in the register for one cycle and is pushed the
  // cycle after its second byte arrived.
  assign full_word   = asm_valid & (asm_be == 2'b11);
  // Accepted bytes clear the counter, so the timeout never fires on an edge.
  assign timeout_hit = asm_valid & ~byte_edge & (to_cnt == TIMEOUT_LAST);
  assign flush       = ~byte_edge & (full_word | timeout_hit);
  // The pushed word is always the one currently held, so one push per cycle.
  assign push        = evict | flush;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation order cannot change behaviour.
  always_ff @(posedge clk_memory or posedge reset) begin
    if (reset) begin
      prev_en   <= 1'b0;
      asm_valid <= 1'b0;
      asm_addr  <= '0;
      asm_data  <= '0;
      asm_be    <= '0;
      to_cnt    <= '0;
    end else begin
      prev_en <= write_en;
      if (byte_edge) begin
        to_cnt <= '0;
        if (asm_valid && !evict) begin
          asm_data <= asm_data | in_data;
          asm_be   <= asm_be | in_be;
        end else begin
          asm_valid <= 1'b1;
          asm_addr  <= in_waddr;
          asm_data  <= in_data;
          asm_be    <= in_be;
        end
      end else if (flush) begin
        asm_valid <= 1'b0;
        to_cnt    <= '0;
      end else if (asm_valid) begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Word FIFO
  // ---------------------------------------------------------------------------
  logic [ENTRY_W-1:0]         fifo_mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]   count;
  logic                       fifo_full;
  logic                       pop;
  logic                       push_ok;
  logic [ENTRY_W-1:0]         head;

  assign fifo_full = (count == COUNT_FULL);
  assign pop       = mem_req & mem_ack;
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok   = push & (~fifo_full | pop);

  // NOTE: the storage array carries no reset; validity lives in count and the
  // pointers, and leaving the array unreset lets it map onto plain RAM/flops.
  always_ff @(posedge clk_memory) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= {asm_addr, asm_data, asm_be};
    end
  end

  always_ff @(posedge clk_memory or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Controller port
  // ---------------------------------------------------------------------------
  assign head    = fifo_mem[rd_ptr];
  assign mem_req = (count != '0);
  // Head fields are gated so the port reads all-zero whenever nothing is queued.
  assign {mem_addr, mem_wdata, mem_be} = mem_req ? head : '0;
  assign busy    = asm_valid | mem_req;

endmodule

// File: tb/tb_byte_word_packer.sv
// -----------------------------------------------------------------------------
// tb_byte_word_packer
//
// Directed bench for byte_word_packer. Inputs change 2 time units after the
// rising clock edge; outputs are sampled on the falling edge. A monitor
// records every word the controller accepts (mem_req & mem_ack).
// -----------------------------------------------------------------------------
module tb_byte_word_packer;

  localparam int FT = 15;

  typedef struct packed {
    logic [13:0] addr;
    logic [15:0] data;
    logic [1:0]  be;
  } word_t;

  logic        clk_memory = 1'b0;
  logic        reset      = 1'b1;
  logic        write_en   = 1'b0;
  logic [14:0] write_addr = '0;
  logic [7:0]  write_data = '0;
  logic        mem_ack    = 1'b0;
  logic        mem_req;
  logic [13:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_be;
  logic        busy;
  logic        overflow;

  int checks   = 0;
  int failures = 0;

  word_t obs[$];

  byte_word_packer #(
    .ADDRESS_SIZE   (14),
    .FIFO_DEPTH_LOG2(2),
    .FLUSH_TIMEOUT  (FT)
  ) dut (
    .clk_memory(clk_memory),
    .reset     (reset),
    .write_en  (write_en),
    .write_addr(write_addr),
    .write_data(write_data),
    .mem_req   (mem_req),
    .mem_ack   (mem_ack),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 clk_memory = ~clk_memory;

  always @(negedge clk_memory) begin
    if (!reset && mem_req && mem_ack) obs.push_back({mem_addr, mem_wdata, mem_be});
  end

  function automatic word_t mk(input logic [13:0] a, input logic [15:0] d, input logic [1:0] b);
    return {a, d, b};
  endfunction

  task automatic align();
    @(posedge clk_memory);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) align();
  endtask

  // One rising edge of write_en, held for 'hold' cycles, then one low cycle.
  task automatic send_byte(input logic [14:0] a, input logic [7:0] d, input int hold);
    write_addr = a;
    write_data = d;
    write_en   = 1'b1;
    repeat (hold) @(posedge clk_memory);
    #2 write_en = 1'b0;
    align();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk_memory);
    checks++; if (mem_req !== 1'b0)    begin failures++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (overflow !== 1'b0)   begin failures++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    checks++; if (mem_addr !== 14'h0)  begin failures++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    checks++; if (mem_wdata !== 16'h0) begin failures++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
    checks++; if (mem_be !== 2'b00)    begin failures++; $display("FAIL reset_mem_be: got %b want 0", mem_be); end
    reset = 1'b0;
    align();
  endtask

  task automatic test_full_word();
    mem_ack = 1'b0;
    obs.delete();
    write_addr = 15'h0100; write_data = 8'hAA; write_en = 1'b1;
    align();
    write_en = 1'b0;
    idle(9);
    write_addr = 15'h0101; write_data = 8'hBB; write_en = 1'b1;
    @(posedge clk_memory);
    #2 write_en = 1'b0;
    @(negedge clk_memory);
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL full_req_early: got %b want 0", mem_req); end
    checks++; if (busy !== 1'b1)    begin failures++; $display("FAIL full_busy: got %b want 1", busy); end
    @(negedge clk_memory);
    checks++; if (mem_req !== 1'b1)      begin failures++; $display("FAIL full_req: got %b want 1", mem_req); end
    checks++; if (mem_addr !== 14'h080)  begin failures++; $display("FAIL full_addr: got %h want 080", mem_addr); end
    checks++; if (mem_wdata !== 16'hBBAA) begin failures++; $display("FAIL full_wdata: got %h want bbaa", mem_wdata); end
    checks++; if (mem_be !== 2'b11)      begin failures++; $display("FAIL full_be: got %b want 11", mem_be); end
    align();
    mem_ack = 1'b1;
    idle(3);
    mem_ack = 1'b0;
    checks++; if (obs.size() != 1) begin failures++; $display("FAIL full_count: got %0d want 1", obs.size()); end
    checks++; if (busy !== 1'b0)   begin failures++; $display("FAIL full_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_timeout();
    int k;
    mem_ack = 1'b0;
    obs.delete();
    write_addr = 15'h0203; write_data = 8'h5C; write_en = 1'b1;
    @(posedge clk_memory);
    #2 write_en = 1'b0;
    k = 0;
    @(negedge clk_memory);
    while (!mem_req && k < 40) begin
      k++;
      @(negedge clk_memory);
    end
    checks++; if (k != FT) begin failures++; $display("FAIL timeout_idle_cycles: got %0d want %0d", k, FT); end
    checks++; if (mem_addr !== 14'h101)   begin failures++; $display("FAIL timeout_addr: got %h want 101", mem_addr); end
    checks++; if (mem_wdata !== 16'h5C00) begin failures++; $display("FAIL timeout_wdata: got %h want 5c00", mem_wdata); end
    checks++; if (mem_be !== 2'b10)       begin failures++; $display("FAIL timeout_be: got %b want 10", mem_be); end
    align();
    mem_ack = 1'b1;
    idle(3);
    mem_ack = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL timeout_busy: got %b want 0", busy); end
  endtask

  task automatic test_burst();
    word_t exp[2];
    exp[0] = mk(14'h008, 16'h2211, 2'b11);
    exp[1] = mk(14'h009, 16'h4433, 2'b11);
    mem_ack = 1'b1;
    obs.delete();
    send_byte(15'h0010, 8'h11, 1);
    send_byte(15'h0011, 8'h22, 1);
    send_byte(15'h0012, 8'h33, 1);
    send_byte(15'h0013, 8'h44, 1);
    idle(4);
    checks++; if (obs.size() != 2) begin failures++; $display("FAIL burst_count: got %0d want 2", obs.size()); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= obs.size()) begin
        failures++; $display("FAIL burst_word%0d: got none want %h", i, exp[i]);
      end else if (obs[i] !== exp[i]) begin
        failures++; $display("FAIL burst_word%0d: got %h want %h", i, obs[i], exp[i]);
      end
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL burst_busy: got %b want 0", busy); end
  endtask

  task automatic test_held_enable();
    word_t exp[2];
    exp[0] = mk(14'h000, 16'h0077, 2'b01);
    exp[1] = mk(14'h000, 16'h0012, 2'b01);
    mem_ack = 1'b1;
    obs.delete();
    send_byte(15'h0000, 8'h77, 3);
    send_byte(15'h0000, 8'h12, 2);
    idle(FT + 5);
    checks++; if (obs.size() != 2) begin failures++; $display("FAIL held_count: got %0d want 2", obs.size()); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= obs.size()) begin
        failures++; $display("FAIL held_word%0d: got none want %h", i, exp[i]);
      end else if (obs[i] !== exp[i]) begin
        failures++; $display("FAIL held_word%0d: got %h want %h", i, obs[i], exp[i]);
      end
    end
  endtask

  task automatic test_overflow();
    word_t exp[6];
    for (int i = 0; i < 6; i++) begin
      exp[i] = mk(14'h200 + 14'(i), {8'h20 + 8'(i), 8'h10 + 8'(i)}, 2'b11);
    end
    mem_ack = 1'b0;
    obs.delete();
    for (int i = 0; i < 6; i++) begin
      if (i == 4) begin
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_early: got %b want 0", overflow); end
      end
      send_byte(15'h0400 + 15'(2 * i), 8'h10 + 8'(i), 1);
      send_byte(15'h0401 + 15'(2 * i), 8'h20 + 8'(i), 1);
    end
    idle(1);
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set: got %b want 1", overflow); end
    checks++; if (mem_req !== 1'b1)  begin failures++; $display("FAIL ovf_req: got %b want 1", mem_req); end
    mem_ack = 1'b1;
    idle(8);
    mem_ack = 1'b0;
    checks++; if (obs.size() != 4) begin failures++; $display("FAIL ovf_count: got %0d want 4", obs.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= obs.size()) begin
        failures++; $display("FAIL ovf_word%0d: got none want %h", i, exp[i]);
      end else if (obs[i] !== exp[i]) begin
        failures++; $display("FAIL ovf_word%0d: got %h want %h", i, obs[i], exp[i]);
      end
    end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL ovf_busy: got %b want 0", busy); end
  endtask

  task automatic test_reset_midop();
    word_t exp_new;
    exp_new = mk(14'h400, 16'hA55A, 2'b11);
    mem_ack = 1'b0;
    obs.delete();
    send_byte(15'h0600, 8'h01, 1);
    send_byte(15'h0601, 8'h02, 1);
    send_byte(15'h0700, 8'h03, 1);
    idle(1);
    checks++; if (mem_req !== 1'b1)  begin failures++; $display("FAIL midrst_pre_req: got %b want 1", mem_req); end
    checks++; if (busy !== 1'b1)     begin failures++; $display("FAIL midrst_pre_busy: got %b want 1", busy); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL midrst_pre_ovf: got %b want 1", overflow); end
    #1 reset = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0)  begin failures++; $display("FAIL midrst_req: got %b want 0", mem_req); end
    checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL midrst_busy: got %b want 0", busy); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL midrst_ovf: got %b want 0", overflow); end
    repeat (2) @(negedge clk_memory);
    reset = 1'b0;
    align();
    mem_ack = 1'b1;
    obs.delete();
    idle(FT + 10);
    checks++; if (obs.size() != 0) begin failures++; $display("FAIL midrst_stale: got %0d words want 0", obs.size()); end
    checks++; if (busy !== 1'b0)   begin failures++; $display("FAIL midrst_idle_busy: got %b want 0", busy); end
    send_byte(15'h0800, 8'h5A, 1);
    send_byte(15'h0801, 8'hA5, 1);
    idle(3);
    checks++;
    if (obs.size() != 1) begin
      failures++; $display("FAIL midrst_new_count: got %0d want 1", obs.size());
    end else if (obs[0] !== exp_new) begin
      failures++; $display("FAIL midrst_new_word: got %h want %h", obs[0], exp_new);
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_timeout();
    test_burst();
    test_held_enable();
    test_overflow();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
